// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap helper for the K=3 convolutional
// encoder and its companion Viterbi decoder.
package conv_pkg;

   localparam int             K             = 3;
   localparam int             INFO_BITS_DEF = 29;
   localparam logic [K-1:0]   G0_DEF        = 3'b111;
   localparam logic [K-1:0]   G1_DEF        = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } conv_state_e;

   // Taps are ordered {d, s1, s0}; a generator bit of 1 includes that tap.
   function automatic logic conv_tap(input logic [K-1:0] taps, input logic [K-1:0] g);
      return ^(taps & g);
   endfunction

endpackage

// File: rtl/conv_enc.sv
// Rate-1/2, K=3 zero-terminated convolutional encoder producing framed
// 2-bit symbols (INFO_BITS data symbols + 2 tail symbols) for the QAM mapper.
module conv_enc
   import conv_pkg::*;
#(
   parameter int           INFO_BITS = INFO_BITS_DEF,
   parameter logic [K-1:0] G0        = G0_DEF,
   parameter logic [K-1:0] G1        = G1_DEF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [1:0] conv_out,
   output logic       out_valid,
   output logic       frame_start,
   output logic       frame_end
);

   localparam int               CNT_W    = $clog2(INFO_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INFO_BITS);

   conv_state_e      r_state;
   logic [1:0]       r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tail_cnt;
   logic [1:0]       r_conv_out;
   logic             r_out_valid;
   logic             r_frame_start;
   logic             r_frame_end;

   logic             w_d;
   logic [K-1:0]     w_taps;
   logic [1:0]       w_sym;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Tail cycles force a zero input so the register flushes back to 00.
   assign w_d       = (r_state == TAIL) ? 1'b0 : data_in;
   assign w_taps    = {w_d, r_sr};
   assign w_sym     = {conv_tap(w_taps, G0), conv_tap(w_taps, G1)};
   assign w_cnt_nxt = r_cnt + CNT_ONE;

   assign in_ready    = (r_state != TAIL);
   assign conv_out    = r_conv_out;
   assign out_valid   = r_out_valid;
   assign frame_start = r_frame_start;
   assign frame_end   = r_frame_end;

   // Frame FSM, shift register, bit counter and registered symbol outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_sr          <= 2'b00;
         r_cnt         <= '0;
         r_tail_cnt    <= 1'b0;
         r_conv_out    <= 2'b00;
         r_out_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
      end else begin
         r_out_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_conv_out    <= w_sym;
                  r_out_valid   <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_sr          <= {w_d, r_sr[1]};
                  r_cnt         <= CNT_ONE;
                  r_state       <= (CNT_ONE == CNT_LAST) ? TAIL : DATA;
               end else begin
                  r_state <= IDLE;
               end
            end
            DATA: begin
               if (in_valid) begin
                  r_conv_out  <= w_sym;
                  r_out_valid <= 1'b1;
                  r_sr        <= {w_d, r_sr[1]};
                  r_cnt       <= w_cnt_nxt;
                  r_state     <= (w_cnt_nxt == CNT_LAST) ? TAIL : DATA;
               end else begin
                  r_state <= DATA;
               end
            end
            TAIL: begin
               r_conv_out  <= w_sym;
               r_out_valid <= 1'b1;
               if (r_tail_cnt) begin
                  r_frame_end <= 1'b1;
                  r_sr        <= 2'b00;
                  r_cnt       <= '0;
                  r_tail_cnt  <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_sr        <= {w_d, r_sr[1]};
                  r_tail_cnt  <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_sr       <= 2'b00;
               r_cnt      <= '0;
               r_tail_cnt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc: frame patterns, stall, mid-frame reset and
// back-to-back frames with hand-computed and model-derived symbols.
module tb_conv_enc;

   logic       clk;
   logic       rst_n;
   logic       data_in;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] conv_out;
   logic       out_valid;
   logic       frame_start;
   logic       frame_end;

   int n_vec;
   int n_bad;

   conv_enc dut (
      .clk        (clk),
      .reset      (rst_n),
      .data_in    (data_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .conv_out   (conv_out),
      .out_valid  (out_valid),
      .frame_start(frame_start),
      .frame_end  (frame_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference for the default code: sym = {d^s1^s0, d^s0}, symbol i at [2i+:2].
   function automatic logic [61:0] model(input logic [28:0] b);
      logic [61:0] r;
      logic        s1, s0, d;
      r  = '0;
      s1 = 1'b0;
      s0 = 1'b0;
      for (int i = 0; i < 31; i++) begin
         d = 1'b0;
         if (i < 29) d = b[i];
         r[2*i+1] = d ^ s1 ^ s0;
         r[2*i]   = d ^ s0;
         s0 = s1;
         s1 = d;
      end
      return r;
   endfunction

   task automatic run_frame(input string name, input logic [28:0] bits, input int stall_at,
                            input logic [61:0] exp, output logic [61:0] got);
      logic [1:0] prev;
      got  = '0;
      prev = conv_out;
      for (int i = 0; i < 29; i++) begin
         if (i == stall_at) begin
            for (int j = 0; j < 3; j++) begin
               in_valid = 1'b0;
               data_in  = ~bits[i];
               step();
               n_vec++;
               if (out_valid !== 1'b0 || conv_out !== prev || in_ready !== 1'b1) begin
                  n_bad++;
                  $display("FAIL %s stall%0d: out_valid=%b conv_out=%b in_ready=%b, want 0 %b 1",
                           name, j, out_valid, conv_out, in_ready, prev);
               end
            end
         end
         in_valid = 1'b1;
         data_in  = bits[i];
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready bit%0d: in_ready=%b, want 1", name, i, in_ready);
         end
         step();
         n_vec++;
         if (out_valid !== 1'b1 || conv_out !== exp[2*i+:2] ||
             frame_start !== 1'(i == 0) || frame_end !== 1'b0) begin
            n_bad++;
            $display("FAIL %s sym%0d: v=%b sym=%b fs=%b fe=%b, want v=1 sym=%b fs=%b fe=0",
                     name, i, out_valid, conv_out, frame_start, frame_end, exp[2*i+:2], (i == 0));
         end
         got[2*i+:2] = conv_out;
         prev        = conv_out;
      end
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1;
         data_in  = 1'b1;
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready tail%0d: in_ready=%b, want 0", name, t, in_ready);
         end
         step();
         n_vec++;
         if (out_valid !== 1'b1 || conv_out !== exp[2*(29+t)+:2] ||
             frame_start !== 1'b0 || frame_end !== 1'(t == 1)) begin
            n_bad++;
            $display("FAIL %s tail%0d: v=%b sym=%b fs=%b fe=%b, want v=1 sym=%b fs=0 fe=%b",
                     name, t, out_valid, conv_out, frame_start, frame_end,
                     exp[2*(29+t)+:2], (t == 1));
         end
         got[2*(29+t)+:2] = conv_out;
      end
      in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready after tail: in_ready=%b, want 1", name, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = 1'b0;
      step();
      step();
      n_vec++;
      if (conv_out !== 2'b00 || out_valid !== 1'b0 || frame_start !== 1'b0 || frame_end !== 1'b0) begin
         n_bad++;
         $display("FAIL reset outputs: sym=%b v=%b fs=%b fe=%b, want 00 0 0 0",
                  conv_out, out_valid, frame_start, frame_end);
      end
      rst_n = 1'b1;
      step();
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset release: in_ready=%b v=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_all_zero();
      logic [61:0] g;
      run_frame("all_zero", 29'd0, -1, 62'd0, g);
   endtask

   task automatic test_leading_one();
      logic [61:0] g;
      run_frame("leading_one", 29'd1, -1, 62'h3B, g);
   endtask

   task automatic test_final_one();
      logic [61:0] g;
      logic [61:0] e;
      logic [28:0] b;
      e = 62'h3B;
      e = e << 56;
      b = 29'd1;
      b = b << 28;
      run_frame("final_one", b, -1, e, g);
   endtask

   task automatic test_stall();
      logic [61:0] g1, g2;
      logic [28:0] pat;
      pat = 29'h0B5AC3D1;
      run_frame("nostall", pat, -1, model(pat), g1);
      run_frame("stall", pat, 10, model(pat), g2);
      n_vec++;
      if (g2 !== g1) begin
         n_bad++;
         $display("FAIL stall_vs_nostall: got=%h want=%h", g2, g1);
      end
   endtask

   task automatic test_reset_mid();
      logic [61:0] g;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         data_in  = 1'b1;
         step();
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (conv_out !== 2'b00 || out_valid !== 1'b0 || frame_start !== 1'b0 ||
          frame_end !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset: sym=%b v=%b fs=%b fe=%b rdy=%b, want 00 0 0 0 1",
                  conv_out, out_valid, frame_start, frame_end, in_ready);
      end
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      run_frame("after_reset", 29'd1, -1, 62'h3B, g);
   endtask

   task automatic test_back_to_back();
      logic [28:0] b [2];
      logic [61:0] g [2];
      logic        s1, s0, d;
      b[0] = 29'($urandom);
      b[1] = 29'($urandom);
      run_frame("b2b_0", b[0], -1, model(b[0]), g[0]);
      run_frame("b2b_1", b[1], -1, model(b[1]), g[1]);
      for (int f = 0; f < 2; f++) begin
         s1 = 1'b0;
         s0 = 1'b0;
         for (int i = 0; i < 29; i++) begin
            d = g[f][2*i] ^ s0;
            n_vec++;
            if (d !== b[f][i] || g[f][2*i+1] !== (d ^ s1 ^ s0)) begin
               n_bad++;
               $display("FAIL loopback f%0d bit%0d: decoded=%b sent=%b", f, i, d, b[f][i]);
            end
            s0 = s1;
            s1 = d;
         end
      end
   endtask

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = 1'b0;
      test_reset();
      test_all_zero();
      test_leading_one();
      test_final_one();
      test_leading_one();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_enc.md
CONV_ENC -- requirements
Module: conv_enc

Interface
REQ-001 Parameter INFO_BITS, default 29, information bits per frame; frame length = INFO_BITS+2 = 31 symbols.
REQ-002 Parameter G0, default 3'b111, generator polynomial for symbol bit 1.
REQ-003 Parameter G1, default 3'b101, generator polynomial for symbol bit 0.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  1  information bit.
REQ-007 in_valid  input  1  data_in valid.
REQ-008 in_ready  output  1  encoder accepts data_in this cycle.
REQ-009 conv_out  output  2  coded symbol to QAM mapper: [1]=G0 output, [0]=G1 output.
REQ-010 out_valid  output  1  conv_out valid for exactly this cycle.
REQ-011 frame_start  output  1  high with the first symbol of a frame.
REQ-012 frame_end  output  1  high with the last tail symbol of a frame.

Function
REQ-013 Code SHALL be rate-1/2, constraint length 3, zero-terminated; shift register {s1,s0}, s1 = most recent bit.
REQ-014 With input d: conv_out[1] = d^s1^s0 and conv_out[0] = d^s0 for defaults; in general, XOR of {d,s1,s0} masked by G0/G1.
REQ-015 After each encoded bit, {s1,s0} SHALL become {d,s1}.
REQ-016 FSM states SHALL be IDLE, DATA, TAIL.
REQ-017 IDLE: in_ready=1; on accept (in_valid&&in_ready) encode the bit, bit counter=1, go to DATA.
REQ-018 DATA: in_ready=1; each accept encodes the bit and increments the counter; the accept that makes the counter equal INFO_BITS goes to TAIL.
REQ-019 TAIL: in_ready=0; encode d=0 on each of exactly 2 consecutive cycles regardless of in_valid, then go to IDLE with {s1,s0}=00.
REQ-020 Latency: conv_out/out_valid SHALL be registered and appear one cycle after the accept or tail cycle.
REQ-021 in_valid low in IDLE/DATA SHALL stall: out_valid=0; shift register, counter and state held; conv_out holds its last value.
REQ-022 frame_start SHALL accompany the symbol of the first accepted bit; frame_end SHALL accompany the second tail symbol; both are single-cycle and qualified by out_valid.
REQ-023 Back-to-back frames: the cycle after the second tail cycle (IDLE) SHALL accept a new first bit with no extra gap.
REQ-024 Bit counter width SHALL be $clog2(INFO_BITS+1); it SHALL never exceed INFO_BITS.

Reset
REQ-025 On reset low: state=IDLE, {s1,s0}=00, counter=0, conv_out=00, out_valid=0, frame_start=0, frame_end=0; in_ready=1 once reset is released.
REQ-026 Reset mid-frame SHALL discard the partial frame with no tail emitted; the next accepted bit starts a new frame.

Structure
REQ-027 Shared package conv_pkg SHALL hold K=3, default INFO_BITS, G0/G1 constants and the FSM state enum, shared with the Viterbi decoder.
REQ-028 No sub-module is required; the encoder SHALL be a single module.

Verification
REQ-029 All-zero frame, in_valid held high -> 31 symbols of 00; frame_start on the 1st, frame_end on the 31st; in_ready low exactly 2 cycles.
REQ-030 Bit 1 first, then 28 zeros -> symbols 11,10,11, then 00 for the remaining 28 symbols.
REQ-031 28 zeros then a final 1 -> symbol 29 = 11; tail symbols 30,31 = 10,11; encoder returns to state 00.
REQ-032 Drop in_valid for 3 cycles after bit 10 -> no out_valid for those cycles; the symbol sequence is identical to the unstalled run.
REQ-033 Assert reset after bit 15 (data 1s) -> all outputs zero at once; the next frame of a single leading 1 produces 11,10,11, matching REQ-030.
REQ-034 Two frames back-to-back, random data -> output matches a loop-back through the decoder and the golden model bit-exactly, with zero idle cycles between frames.
